farrow_interpolator: RTL and testbench
======================================

// Module: farrow_interpolator
// PURPOSE
//  Piecewise-parabolic Farrow interpolator (alpha = 0.5), directly downstream of the NCO in the Gardner STR loop.
//  Keeps a 4-tap delay line of input samples; on each NCO strobe it evaluates the signal at fractional offset u_k
//  between taps[2] and taps[1] and emits one symbol-rate sample for the TED. 3-stage pipeline, no stall.
// PARAMETERS
//  DW      16  input/output sample width, signed Q1.15
//  MUW     16  fractional offset width, unsigned 1.15; valid range 0..32767
//  IW      DW+2  internal coefficient width (v1/v2 headroom)
// PORTS
//  clk        in   1      system clock, rising edge
//  reset      in   1      synchronous, active-high
//  sample_en  in   1      input sample valid (same enable that drives the NCO loop_out_en)
//  x_in       in   DW     signed input sample
//  strobe     in   1      NCO strobe: interpolate this cycle
//  u_k        in   MUW    NCO fractional offset mu, Q0.15
//  m_k        in   16     NCO symbol index, signed
//  y_out      out  DW     signed interpolated sample
//  y_valid    out  1      one-cycle pulse, y_out/m_out valid
//  m_out      out  16     m_k captured with the strobe that produced y_out
//  sat_flag   out  1      sticky: set when any y_out was clipped
// BEHAVIOUR
//  Reset: taps[0..3] = 0, all pipeline valids = 0, y_out = 0, y_valid = 0, m_out = 0, sat_flag = 0.
//   Reset mid-operation discards in-flight results; no y_valid in the cycle after reset deasserts.
//  Delay line: on sample_en, taps[0] <= x_in, taps[k] <= taps[k-1]; taps[0] is the newest sample.
//  Stage 1 (cycle of strobe=1): operands are the taps registered before that edge, i.e. a sample_en in the same
//   cycle does not affect this interpolation. Register mu = u_k, m = m_k and:
//    v0 = taps[2]
//    v1 = (-taps[0] + 3*taps[1] - taps[2] - taps[3]) >>> 1
//    v2 = ( taps[0] -   taps[1] - taps[2] + taps[3]) >>> 1
//   Sums in IW+1 bits, then arithmetic shift; v1/v2 stored in IW bits (no overflow possible).
//  Stage 2: t = ((v2 * mu) >>> 15) + v1     (mu zero-extended; product IW+MUW+1 bits; floor truncation)
//  Stage 3: y = ((t * mu) >>> 15) + v0; saturate to [-32768, 32767]; y_out <= y; y_valid <= 1; m_out <= m.
//   If clipping occurred: sat_flag <= 1 (cleared only by reset).
//  Latency: strobe at edge N -> y_valid high for exactly one cycle after edge N+3 (3 cycles).
//  Throughput: strobe accepted every cycle; back-to-back strobes give back-to-back y_valid, in order.
//  strobe=0: nothing enters the pipeline; y_out holds its last value; y_valid = 0.
//  u_k > 32767 is out of contract; the datapath computes it without special handling (no assertion).
//  Endpoints: mu = 0 -> y = taps[2] exactly; mu -> 1 approaches taps[1].
//  Linear input is reproduced exactly (v2 = 0) up to the floor truncation of the mu products.
// TESTING
//  1. Constant x_in = 0x2000 for 8 samples, strobe with u_k = 0, 12000, 32767 -> y_out = 0x2000 each, sat_flag = 0.
//  2. Ramp x = 0,100,200,300 (300 newest), strobe u_k = 16384 -> y_out = 150 three cycles later;
//     u_k = 0 -> y_out = 100.
//  3. Taps (oldest..newest) 0,32767,32767,0, u_k = 16384 -> unclipped value 40958 -> y_out = 32767,
//     sat_flag = 1 and stays 1.
//  4. Strobes on 4 consecutive cycles with m_k = 5,6,7,8 -> 4 consecutive y_valid pulses with m_out = 5,6,7,8,
//     first pulse 3 cycles after first strobe.
//  5. strobe and sample_en in the same cycle -> result uses the pre-shift taps (compare against a model fed the
//     old taps).
//  6. Strobe, then reset asserted 1 cycle later -> no y_valid; y_out = 0, sat_flag = 0, taps cleared;
//     next strobe with taps = 0 gives y_out = 0.

Source files
------------

// File: rtl/farrow_interpolator.sv
// Piecewise-parabolic (alpha = 0.5) Farrow interpolator between the NCO and the Gardner TED.
// Three pipeline stages: coefficient build, first Horner step, second Horner step with output saturation.
module farrow_interpolator #(
  parameter int DW  = 16,
  parameter int MUW = 16,
  parameter int IW  = DW + 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_en,
  input  logic signed [DW-1:0]  x_in,
  input  logic                  strobe,
  input  logic        [MUW-1:0] u_k,
  input  logic signed [15:0]    m_k,
  output logic signed [DW-1:0]  y_out,
  output logic                  y_valid,
  output logic signed [15:0]    m_out,
  output logic                  sat_flag
);

  localparam int SW  = IW + 1;
  localparam int TW  = IW + 2;
  localparam int PW  = IW + MUW + 1;
  localparam int P3W = TW + MUW + 1;
  localparam int YW  = TW + 3;
  localparam int SH  = MUW - 1;

  localparam logic signed [YW-1:0] Y_MAX = YW'((2 ** (DW - 1)) - 1);
  localparam logic signed [YW-1:0] Y_MIN = YW'(-(2 ** (DW - 1)));

  logic signed [DW-1:0]  taps [4];

  logic signed [SW-1:0]  e0, e1, e2, e3;
  logic signed [SW-1:0]  sum1, sum2;

  logic                  s1_valid;
  logic signed [DW-1:0]  s1_v0;
  logic signed [IW-1:0]  s1_v1, s1_v2;
  logic        [MUW-1:0] s1_mu;
  logic signed [15:0]    s1_m;

  logic signed [PW-1:0]  prod2;
  logic signed [TW-1:0]  t_next;

  logic                  s2_valid;
  logic signed [DW-1:0]  s2_v0;
  logic signed [TW-1:0]  s2_t;
  logic        [MUW-1:0] s2_mu;
  logic signed [15:0]    s2_m;

  logic signed [P3W-1:0] prod3;
  logic signed [YW-1:0]  y_wide;
  logic signed [DW-1:0]  y_sat;
  logic                  clip;

  logic                  unused_bits;

  // Delay line; taps[0] is the newest sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) taps[k] <= '0;
    end else if (sample_en) begin
      taps[0] <= x_in;
      for (int k = 1; k < 4; k++) taps[k] <= taps[k-1];
    end
  end

  assign e0 = SW'(taps[0]);
  assign e1 = SW'(taps[1]);
  assign e2 = SW'(taps[2]);
  assign e3 = SW'(taps[3]);

  assign sum1 = -e0 + (e1 <<< 1) + e1 - e2 - e3;
  assign sum2 =  e0 - e1 - e2 + e3;

  // Stage 1 sees the taps from before this edge, so a coincident sample_en does not disturb it.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_v0    <= '0;
      s1_v1    <= '0;
      s1_v2    <= '0;
      s1_mu    <= '0;
      s1_m     <= '0;
    end else begin
      s1_valid <= strobe;
      if (strobe) begin
        s1_v0 <= taps[2];
        s1_v1 <= sum1[SW-1:1];
        s1_v2 <= sum2[SW-1:1];
        s1_mu <= u_k;
        s1_m  <= m_k;
      end
    end
  end

  assign prod2  = PW'(s1_v2) * PW'($signed({1'b0, s1_mu}));
  assign t_next = $signed(prod2[PW-1:SH]) + TW'(s1_v1);

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_v0    <= '0;
      s2_t     <= '0;
      s2_mu    <= '0;
      s2_m     <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_v0 <= s1_v0;
        s2_t  <= t_next;
        s2_mu <= s1_mu;
        s2_m  <= s1_m;
      end
    end
  end

  assign prod3  = P3W'(s2_t) * P3W'($signed({1'b0, s2_mu}));
  assign y_wide = YW'($signed(prod3[P3W-1:SH])) + YW'(s2_v0);

  always_comb begin
    y_sat = y_wide[DW-1:0];
    clip  = 1'b0;
    if (y_wide > Y_MAX) begin
      y_sat = Y_MAX[DW-1:0];
      clip  = 1'b1;
    end else if (y_wide < Y_MIN) begin
      y_sat = Y_MIN[DW-1:0];
      clip  = 1'b1;
    end
  end

  // y_out holds between results; sat_flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      y_out    <= '0;
      y_valid  <= 1'b0;
      m_out    <= '0;
      sat_flag <= 1'b0;
    end else begin
      y_valid <= s2_valid;
      if (s2_valid) begin
        y_out <= y_sat;
        m_out <= s2_m;
        if (clip) sat_flag <= 1'b1;
      end
    end
  end

  assign unused_bits = ^{sum1[0], sum2[0], prod2[SH-1:0], prod3[SH-1:0]};

endmodule

// File: tb/tb_farrow_interpolator.sv
// Scoreboard bench for farrow_interpolator: expected samples are queued from a behavioural model
// when a strobe is driven and matched against outputs captured on the falling edge.
module tb_farrow_interpolator;

  logic               clk;
  logic               reset;
  logic               sample_en;
  logic signed [15:0] x_in;
  logic               strobe;
  logic        [15:0] u_k;
  logic signed [15:0] m_k;
  logic signed [15:0] y_out;
  logic               y_valid;
  logic signed [15:0] m_out;
  logic               sat_flag;

  typedef struct {
    logic signed [15:0] y;
    logic signed [15:0] m;
    int                 c;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];

  int checks;
  int errors;
  int cyc;
  logic signed [15:0] mtaps [4];
  logic model_sat;

  farrow_interpolator #(.DW(16), .MUW(16), .IW(18)) dut (
    .clk       (clk),
    .reset     (reset),
    .sample_en (sample_en),
    .x_in      (x_in),
    .strobe    (strobe),
    .u_k       (u_k),
    .m_k       (m_k),
    .y_out     (y_out),
    .y_valid   (y_valid),
    .m_out     (m_out),
    .sat_flag  (sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference parabolic interpolator with floor-truncated mu products, unsaturated.
  function automatic longint model_y(input logic signed [15:0] t0, input logic signed [15:0] t1,
                                     input logic signed [15:0] t2, input logic signed [15:0] t3,
                                     input logic [15:0] mu);
    longint a0, a1, a2, a3, m, v1, v2, t;
    a0 = t0;
    a1 = t1;
    a2 = t2;
    a3 = t3;
    m  = longint'(mu);
    v1 = (-a0 + 3 * a1 - a2 - a3) >>> 1;
    v2 = (a0 - a1 - a2 + a3) >>> 1;
    t  = ((v2 * m) >>> 15) + v1;
    return ((t * m) >>> 15) + a2;
  endfunction

  // Drive one cycle of inputs at the falling edge, then record any output seen on the next falling edge.
  task automatic step_cycle(input logic se, input logic signed [15:0] x, input logic st,
                            input logic [15:0] u, input logic signed [15:0] m);
    rec_t r;
    longint yy;
    sample_en = se;
    x_in      = x;
    strobe    = st;
    u_k       = u;
    m_k       = m;
    if (st) begin
      yy = model_y(mtaps[0], mtaps[1], mtaps[2], mtaps[3], u);
      if (yy > 32767) begin
        yy = 32767;
        model_sat = 1'b1;
      end else if (yy < -32768) begin
        yy = -32768;
        model_sat = 1'b1;
      end
      r.y = 16'(yy);
      r.m = m;
      r.c = cyc + 3;
      exp_q.push_back(r);
    end
    if (se) begin
      mtaps[3] = mtaps[2];
      mtaps[2] = mtaps[1];
      mtaps[1] = mtaps[0];
      mtaps[0] = x;
    end
    @(negedge clk);
    cyc++;
    if (y_valid) begin
      r.y = y_out;
      r.m = m_out;
      r.c = cyc;
      obs_q.push_back(r);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step_cycle(1'b0, 16'sd0, 1'b0, 16'd0, 16'sd0);
  endtask

  task automatic load(input logic signed [15:0] a, input logic signed [15:0] b,
                      input logic signed [15:0] c, input logic signed [15:0] d);
    step_cycle(1'b1, a, 1'b0, 16'd0, 16'sd0);
    step_cycle(1'b1, b, 1'b0, 16'd0, 16'sd0);
    step_cycle(1'b1, c, 1'b0, 16'd0, 16'sd0);
    step_cycle(1'b1, d, 1'b0, 16'd0, 16'sd0);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    sample_en = 1'b0;
    strobe    = 1'b0;
    x_in      = '0;
    u_k       = '0;
    m_k       = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({y_out, m_out} !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_data: y_out=%0d m_out=%0d, required 0 and 0", y_out, m_out);
    end
    checks++;
    if (y_valid !== 1'b0 || sat_flag !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: y_valid=%b sat_flag=%b, required 0 and 0", y_valid, sat_flag);
    end
    reset = 1'b0;
    idle(1);
    checks++;
    if (y_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release_valid: y_valid=%b, required 0", y_valid);
    end
  endtask

  task automatic test_constant();
    rec_t o;
    for (int i = 0; i < 8; i++) step_cycle(1'b1, 16'sh2000, 1'b0, 16'd0, 16'sd0);
    step_cycle(1'b0, 16'sd0, 1'b1, 16'd0, 16'sd1);
    step_cycle(1'b0, 16'sd0, 1'b1, 16'd12000, 16'sd2);
    step_cycle(1'b0, 16'sd0, 1'b1, 16'd32767, 16'sd3);
    idle(4);
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL const_y%0d: no output, required y=8192", i);
      end else begin
        o = obs_q.pop_front();
        if (o.y !== 16'sh2000) begin
          errors++;
          $display("[TB] FAIL const_y%0d: y=%0d, required 8192", i, o.y);
        end
      end
    end
    checks++;
    if (sat_flag !== 1'b0 || obs_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL const_tail: sat_flag=%b extra=%0d, required 0 and 0", sat_flag, obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_ramp();
    rec_t o;
    int s_cyc;
    load(16'sd0, 16'sd100, 16'sd200, 16'sd300);
    s_cyc = cyc;
    step_cycle(1'b0, 16'sd0, 1'b1, 16'd16384, 16'sd10);
    idle(4);
    step_cycle(1'b0, 16'sd0, 1'b1, 16'd0, 16'sd11);
    idle(4);
    exp_q.delete();
    checks++;
    if (obs_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL ramp_mid: no output, required y=150");
    end else begin
      o = obs_q.pop_front();
      if (o.y !== 16'sd150 || o.m !== 16'sd10 || o.c != s_cyc + 3) begin
        errors++;
        $display("[TB] FAIL ramp_mid: y=%0d m=%0d cyc=%0d, required 150 10 %0d", o.y, o.m, o.c, s_cyc + 3);
      end
    end
    checks++;
    if (obs_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL ramp_mu0: no output, required y=100");
    end else begin
      o = obs_q.pop_front();
      if (o.y !== 16'sd100 || o.m !== 16'sd11) begin
        errors++;
        $display("[TB] FAIL ramp_mu0: y=%0d m=%0d, required 100 11", o.y, o.m);
      end
    end
    obs_q.delete();
  endtask

  task automatic test_saturation();
    rec_t o;
    load(16'sd0, 16'sd32767, 16'sd32767, 16'sd0);
    step_cycle(1'b0, 16'sd0, 1'b1, 16'd16384, 16'sd12);
    idle(4);
    exp_q.delete();
    checks++;
    if (obs_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL sat_y: no output, required y=32767");
    end else begin
      o = obs_q.pop_front();
      if (o.y !== 16'sd32767 || sat_flag !== 1'b1) begin
        errors++;
        $display("[TB] FAIL sat_y: y=%0d sat_flag=%b, required 32767 1", o.y, sat_flag);
      end
    end
    load(16'sd1, 16'sd2, 16'sd3, 16'sd4);
    step_cycle(1'b0, 16'sd0, 1'b1, 16'd8000, 16'sd13);
    idle(4);
    exp_q.delete();
    obs_q.delete();
    checks++;
    if (sat_flag !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sat_sticky: sat_flag=%b, required 1", sat_flag);
    end
  endtask

  task automatic test_back_to_back();
    rec_t e, o;
    load(16'($urandom_range(65535)), 16'($urandom_range(65535)),
         16'($urandom_range(65535)), 16'($urandom_range(65535)));
    for (int i = 0; i < 4; i++)
      step_cycle(1'b0, 16'sd0, 1'b1, 16'($urandom_range(32767)), 16'(5 + i));
    idle(5);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL b2b: missing output, required y=%0d m=%0d", e.y, e.m);
      end else begin
        o = obs_q.pop_front();
        if (o.y !== e.y || o.m !== e.m || o.c != e.c) begin
          errors++;
          $display("[TB] FAIL b2b: y=%0d m=%0d cyc=%0d, required %0d %0d %0d", o.y, o.m, o.c, e.y, e.m, e.c);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL b2b_extra: %0d extra outputs, required 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_coincident();
    rec_t e, o;
    load(16'sd1200, -16'sd3400, 16'sd5600, -16'sd700);
    step_cycle(1'b1, 16'sd9000, 1'b1, 16'd20000, 16'sd20);
    step_cycle(1'b0, 16'sd0, 1'b1, 16'd20000, 16'sd21);
    for (int i = 0; i < 3; i++)
      step_cycle(1'b1, 16'($urandom_range(65535)), 1'b1, 16'($urandom_range(32767)), 16'(22 + i));
    idle(5);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL coincident: missing output, required y=%0d m=%0d", e.y, e.m);
      end else begin
        o = obs_q.pop_front();
        if (o.y !== e.y || o.m !== e.m || o.c != e.c) begin
          errors++;
          $display("[TB] FAIL coincident: y=%0d m=%0d cyc=%0d, required %0d %0d %0d", o.y, o.m, o.c, e.y, e.m, e.c);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL coincident_extra: %0d extra outputs, required 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_reset_midflight();
    rec_t o;
    load(16'sd1000, 16'sd2000, 16'sd3000, 16'sd4000);
    sample_en = 1'b0;
    strobe    = 1'b1;
    u_k       = 16'd16384;
    m_k       = 16'sd30;
    @(negedge clk);
    cyc++;
    strobe = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    cyc++;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) mtaps[k] = '0;
    model_sat = 1'b0;
    exp_q.delete();
    idle(5);
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL midreset_valid: %0d outputs, required 0", obs_q.size());
    end
    obs_q.delete();
    checks++;
    if (y_out !== 16'sd0 || m_out !== 16'sd0 || sat_flag !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_state: y=%0d m=%0d sat=%b, required 0 0 0", y_out, m_out, sat_flag);
    end
    step_cycle(1'b0, 16'sd0, 1'b1, 16'd16384, 16'sd31);
    idle(4);
    exp_q.delete();
    checks++;
    if (obs_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL midreset_taps: no output, required y=0 m=31");
    end else begin
      o = obs_q.pop_front();
      if (o.y !== 16'sd0 || o.m !== 16'sd31) begin
        errors++;
        $display("[TB] FAIL midreset_taps: y=%0d m=%0d, required 0 31", o.y, o.m);
      end
    end
    obs_q.delete();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    model_sat = 1'b0;
    for (int k = 0; k < 4; k++) mtaps[k] = '0;
    test_reset();
    test_constant();
    test_ramp();
    test_saturation();
    test_back_to_back();
    test_coincident();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
